// File: rtl/frame_sequencer_pkg.sv
// Shared constants for the frame sequencer and its key debouncers.
//   - 3-bit sequencer state encodings
//   - platform geometry (PLATSIZE, PLATY)
//   - default frame and debounce periods for a 50 MHz clock
//   - colour used for the erase pass
package frame_sequencer_pkg;

  localparam logic [2:0] S_IDLE       = 3'd0;
  localparam logic [2:0] S_ERASE_GO   = 3'd1;
  localparam logic [2:0] S_ERASE_WAIT = 3'd2;
  localparam logic [2:0] S_MOVE       = 3'd3;
  localparam logic [2:0] S_DRAW_GO    = 3'd4;
  localparam logic [2:0] S_DRAW_WAIT  = 3'd5;

  localparam int unsigned PLATSIZE = 16;
  localparam int unsigned PLATY    = 110;

  // 60 Hz frame and 5 ms debounce at 50 MHz
  localparam int unsigned FRAME_CYCLES_DEF    = 833333;
  localparam int unsigned DEBOUNCE_CYCLES_DEF = 250000;

  localparam logic [2:0] COLOUR_BLACK = 3'b000;

endpackage

// File: rtl/frame_sequencer_key_debounce.sv
// key_debounce: two-flop synchroniser and debounce filter for one raw push-button.
//   clk    in  system clock
//   resetn in  synchronous active-low reset
//   key_n  in  raw active-low button, asynchronous to clk
//   held   out debounced active-high level (1 = pressed)
module key_debounce #(
  parameter int unsigned DEBOUNCE_CYCLES = 250000
) (
  input  logic clk,
  input  logic resetn,
  input  logic key_n,
  output logic held
);

  localparam int unsigned DW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [DW-1:0] CNT_LAST = DW'(DEBOUNCE_CYCLES - 1);

  // Inverted ahead of the flops so a reset value of 0 means "released" throughout.
  logic          sync1_q, sync2_q;
  logic          held_q;
  logic [DW-1:0] cnt_q;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      held_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= ~key_n;
      sync2_q <= sync1_q;
      if (sync2_q == held_q) begin
        cnt_q <= '0;
      end else if (cnt_q == CNT_LAST) begin
        // DEBOUNCE_CYCLES consecutive differing cycles seen
        held_q <= sync2_q;
        cnt_q  <= '0;
      end else begin
        cnt_q <= cnt_q + 1'b1;
      end
    end
  end

  assign held = held_q;

endmodule

// File: rtl/frame_sequencer.sv
// frame_sequencer: once per frame runs erase-old, move, draw-new for the platform drawer.
//   clk, resetn       system clock, synchronous active-low reset
//   key_left_n/right  raw active-low buttons
//   left, right       debounced requests, both masked when both keys held
//   enable            one-cycle move strobe
//   draw              one-cycle draw-start strobe (erase and redraw passes)
//   erase             high across the erase pass; colour mux forces black
//   busy              sequence in progress
//   frame_tick        one-cycle pulse at the frame boundary
//   overrun           one-cycle pulse when a tick lands while busy
module frame_sequencer
  import frame_sequencer_pkg::*;
#(
  parameter int unsigned FRAME_CYCLES    = FRAME_CYCLES_DEF,
  parameter int unsigned DRAW_CYCLES     = PLATSIZE + 2,
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
  input  logic clk,
  input  logic resetn,
  input  logic key_left_n,
  input  logic key_right_n,
  output logic left,
  output logic right,
  output logic enable,
  output logic draw,
  output logic erase,
  output logic busy,
  output logic frame_tick,
  output logic overrun
);

  localparam int unsigned FW = (FRAME_CYCLES > 1) ? $clog2(FRAME_CYCLES) : 1;
  localparam int unsigned WW = (DRAW_CYCLES > 1) ? $clog2(DRAW_CYCLES) : 1;
  localparam logic [FW-1:0] FRAME_LAST = FW'(FRAME_CYCLES - 1);
  localparam logic [WW-1:0] WAIT_LAST  = WW'(DRAW_CYCLES - 1);

  logic          held_left, held_right;
  logic [FW-1:0] frame_cnt_q;
  logic [WW-1:0] wait_cnt_q, wait_cnt_d;
  logic [2:0]    state_q, state_d;

  key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_key_left (
    .clk   (clk),
    .resetn(resetn),
    .key_n (key_left_n),
    .held  (held_left)
  );

  key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_key_right (
    .clk   (clk),
    .resetn(resetn),
    .key_n (key_right_n),
    .held  (held_right)
  );

  assign left  = held_left & ~held_right;
  assign right = held_right & ~held_left;

  // Free-running frame counter, never stalled by the sequence
  always_ff @(posedge clk) begin
    if (!resetn) begin
      frame_cnt_q <= '0;
    end else if (frame_cnt_q == FRAME_LAST) begin
      frame_cnt_q <= '0;
    end else begin
      frame_cnt_q <= frame_cnt_q + 1'b1;
    end
  end

  assign frame_tick = (frame_cnt_q == FRAME_LAST);

  always_comb begin
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q + 1'b1;
    case (state_q)
      S_IDLE: begin
        if (frame_tick) state_d = S_ERASE_GO;
      end
      S_ERASE_GO: begin
        state_d    = S_ERASE_WAIT;
        wait_cnt_d = '0;
      end
      S_ERASE_WAIT: begin
        if (wait_cnt_q == WAIT_LAST) state_d = S_MOVE;
      end
      S_MOVE: begin
        state_d = S_DRAW_GO;
      end
      S_DRAW_GO: begin
        state_d    = S_DRAW_WAIT;
        wait_cnt_d = '0;
      end
      S_DRAW_WAIT: begin
        if (wait_cnt_q == WAIT_LAST) state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q    <= S_IDLE;
      wait_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
    end
  end

  always_comb begin
    draw    = (state_q == S_ERASE_GO) || (state_q == S_DRAW_GO);
    erase   = (state_q == S_ERASE_GO) || (state_q == S_ERASE_WAIT);
    enable  = (state_q == S_MOVE);
    busy    = (state_q != S_IDLE);
    // A tick while busy is dropped; flag it instead
    overrun = frame_tick && (state_q != S_IDLE);
  end

endmodule

// File: tb/tb_frame_sequencer.sv
// Directed bench for frame_sequencer. Two instances share clock and reset: the main one
// (FRAME_CYCLES=40) and a short-frame one (FRAME_CYCLES=14) that forces ticks while busy.
// Cycle 0 is the first cycle after reset release; outputs are sampled on the falling edge.
module tb_frame_sequencer;

  logic clk = 1'b0;
  logic resetn;
  logic key_left_n, key_right_n;
  logic left, right, enable, draw, erase, busy, frame_tick, overrun;
  logic ov_left, ov_right, ov_enable, ov_draw, ov_erase, ov_busy, ov_frame_tick, ov_overrun;

  int vectors = 0;
  int errors  = 0;
  int cyc     = 0;

  always #5 clk = ~clk;

  frame_sequencer #(
    .FRAME_CYCLES   (40),
    .DRAW_CYCLES    (6),
    .DEBOUNCE_CYCLES(4)
  ) dut (
    .clk        (clk),
    .resetn     (resetn),
    .key_left_n (key_left_n),
    .key_right_n(key_right_n),
    .left       (left),
    .right      (right),
    .enable     (enable),
    .draw       (draw),
    .erase      (erase),
    .busy       (busy),
    .frame_tick (frame_tick),
    .overrun    (overrun)
  );

  frame_sequencer #(
    .FRAME_CYCLES   (14),
    .DRAW_CYCLES    (6),
    .DEBOUNCE_CYCLES(4)
  ) dut_ov (
    .clk        (clk),
    .resetn     (resetn),
    .key_left_n (1'b1),
    .key_right_n(1'b1),
    .left       (ov_left),
    .right      (ov_right),
    .enable     (ov_enable),
    .draw       (ov_draw),
    .erase      (ov_erase),
    .busy       (ov_busy),
    .frame_tick (ov_frame_tick),
    .overrun    (ov_overrun)
  );

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s @cyc %0d: observed %b expected %b", tag, cyc, obs, exp);
    end
  endtask

  task automatic go_to(input int n);
    while (cyc < n) begin
      @(negedge clk);
      cyc++;
    end
  endtask

  initial begin
    resetn      = 1'b0;
    key_left_n  = 1'b1;
    key_right_n = 1'b1;
    repeat (3) @(negedge clk);
    resetn = 1'b1;
    cyc    = 0;

    // Reset state: {frame_tick,busy,draw,erase,enable,overrun,left,right}
    chk("reset_main", {frame_tick, busy, draw, erase, enable, overrun, left, right}, 8'h00);
    chk("reset_ov", {ov_frame_tick, ov_busy, ov_draw, ov_erase, ov_enable, ov_overrun}, 8'h00);

    // Left key pressed from cycle 5: 2 sync + 4 debounce -> cycle 11
    go_to(5);
    key_left_n = 1'b0;
    go_to(10);
    chk("left_before_debounce", {7'd0, left}, 8'd0);
    go_to(11);
    chk("left_after_debounce", {6'd0, left, right}, 8'b10);

    // Short-frame instance: tick 13, sequence 14..28, tick 27 overruns
    go_to(13);
    chk("ov_tick1", {6'd0, ov_frame_tick, ov_overrun}, 8'b10);
    go_to(14);
    chk("ov_erase_go", {4'd0, ov_draw, ov_erase, ov_enable, ov_busy}, 8'b1101);
    go_to(22);
    chk("ov_draw_go", {4'd0, ov_draw, ov_erase, ov_enable, ov_busy}, 8'b1001);
    go_to(27);
    chk("ov_overrun", {5'd0, ov_frame_tick, ov_overrun, ov_busy}, 8'b111);
    go_to(28);
    chk("ov_tick_ignored", {4'd0, ov_draw, ov_erase, ov_overrun, ov_busy}, 8'b0001);
    go_to(29);
    chk("ov_idle_on_time", {7'd0, ov_busy}, 8'd0);

    // Main frame: tick at 39
    go_to(38);
    chk("tick_early", {7'd0, frame_tick}, 8'd0);
    go_to(39);
    chk("tick_39", {5'd0, frame_tick, busy, overrun}, 8'b100);
    go_to(40);
    chk("erase_go", {4'd0, draw, erase, enable, busy}, 8'b1101);
    go_to(41);
    chk("ov_tick3_idle", {5'd0, ov_frame_tick, ov_overrun, ov_busy}, 8'b100);
    go_to(42);
    chk("ov_restart", {4'd0, ov_draw, ov_erase, ov_enable, ov_busy}, 8'b1101);
    for (int c = 41; c <= 46; c++) begin
      go_to(c);
      chk("erase_wait", {4'd0, draw, erase, enable, busy}, 8'b0101);
    end
    go_to(47);
    chk("move", {4'd0, draw, erase, enable, busy}, 8'b0011);
    go_to(48);
    chk("draw_go", {4'd0, draw, erase, enable, busy}, 8'b1001);
    go_to(54);
    chk("draw_wait_last", {4'd0, draw, erase, enable, busy}, 8'b0001);
    go_to(55);
    chk("idle_55", {frame_tick, busy, draw, erase, enable, overrun, 1'b0, right}, 8'h00);
    chk("ov_overrun2", {6'd0, ov_frame_tick, ov_overrun}, 8'b11);

    // Release left: falls 6 cycles later
    go_to(56);
    key_left_n = 1'b1;
    go_to(61);
    chk("left_still_held", {7'd0, left}, 8'd1);
    go_to(62);
    chk("left_released", {7'd0, left}, 8'd0);

    // Right key glitch low for 3 cycles: no output change
    go_to(64);
    key_right_n = 1'b0;
    go_to(67);
    key_right_n = 1'b1;
    for (int c = 67; c <= 76; c++) begin
      go_to(c);
      chk("glitch_right", {7'd0, right}, 8'd0);
    end
    go_to(79);
    chk("tick_79", {7'd0, frame_tick}, 8'd1);

    // Both keys held: masked, move still pulses each frame
    go_to(80);
    key_left_n  = 1'b0;
    key_right_n = 1'b0;
    for (int c = 81; c <= 100; c += 4) begin
      go_to(c);
      chk("both_masked", {6'd0, left, right}, 8'b00);
    end
    go_to(127);
    chk("both_enable", {5'd0, enable, left, right}, 8'b100);
    go_to(130);
    key_right_n = 1'b1;
    go_to(135);
    chk("unmask_pending", {6'd0, left, right}, 8'b00);
    go_to(136);
    chk("unmask_left", {6'd0, left, right}, 8'b10);
    go_to(140);
    key_left_n = 1'b1;

    // Reset during erase wait (tick 159, erase wait 161..166)
    go_to(162);
    chk("pre_reset_erase", {4'd0, draw, erase, enable, busy}, 8'b0101);
    go_to(163);
    resetn = 1'b0;
    go_to(164);
    chk("reset_mid_seq", {frame_tick, busy, draw, erase, enable, overrun, left, right}, 8'h00);
    chk("reset_mid_ov", {6'd0, ov_busy, ov_frame_tick}, 8'h00);
    @(negedge clk);
    resetn = 1'b1;
    cyc    = 0;
    go_to(38);
    chk("rst_tick_early", {6'd0, frame_tick, busy}, 8'b00);
    go_to(39);
    chk("rst_tick_39", {7'd0, frame_tick}, 8'd1);
    go_to(40);
    chk("rst_erase_go", {4'd0, draw, erase, enable, busy}, 8'b1101);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
